// File: rtl/wb_progmem_banks_if.sv
// Wishbone classic slave bus carried between the management SoC and wb_progmem_banks.
interface wb_progmem_banks_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_progmem_banks.sv
// Wishbone window onto NUM_BANKS 1rw1r program-memory macros, core fetch port and RUN/WP control.
// Define PROGMEM_CHECKSUM_EN to add a running checksum of committed writes at control + 4.
module wb_progmem_banks #(
  parameter int          NUM_BANKS = 2,
  parameter int          BANK_AW   = 9,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          BSEL_W    = 1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  wb_progmem_banks_if.slave           wbs,
  output logic [NUM_BANKS-1:0]        bank_csb0,
  output logic                        bank_web0,
  output logic [3:0]                  bank_wmask0,
  output logic [BANK_AW-1:0]          bank_addr0,
  output logic [31:0]                 bank_din0,
  input  logic [32*NUM_BANKS-1:0]     bank_dout0,
  output logic [NUM_BANKS-1:0]        bank_csb1,
  output logic [BANK_AW-1:0]          bank_addr1,
  input  logic [32*NUM_BANKS-1:0]     bank_dout1,
  input  logic                        core_req,
  input  logic [BANK_AW+BSEL_W-1:0]   core_addr,
  output logic [31:0]                 core_data,
  output logic                        core_valid,
  output logic                        core_rst_o
);

  localparam int               CMP_LO      = BANK_AW + BSEL_W + 3;
  localparam logic [BSEL_W:0]  NUM_BANKS_W = (BSEL_W + 1)'(NUM_BANKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t               state_r, next_state_s;

  logic                 hit_s, ctrl_sel_s, bank_ok_s, ctrl_reg_s;
  logic [BSEL_W-1:0]    bus_bank_s;
  logic [BANK_AW-1:0]   bus_word_s;
  logic [31:0]          ctrl_rdata_s;

  logic                 ack_r;
  logic [31:0]          dat_o_r, dat_o_s;
  logic [NUM_BANKS-1:0] csb0_r, csb0_s;
  logic                 web0_r, web0_s;
  logic [3:0]           wmask0_r, wmask0_s;
  logic [BANK_AW-1:0]   addr0_r, addr0_s;
  logic [31:0]          din0_r, din0_s;
  logic [BSEL_W-1:0]    bank_r, bank_s;
  logic                 we_r, we_s;
  logic                 run_r, run_s, wp_r, wp_s, core_rst_r;

  logic [BSEL_W-1:0]    fetch_bank_s, fetch_bank_r;
  logic                 fetch_go_s, fetch_valid_r;
  logic                 unused_s;

  function automatic logic [NUM_BANKS-1:0] bank_sel_n(input logic [BSEL_W-1:0] b);
    logic [NUM_BANKS-1:0] m;
    for (int k = 0; k < NUM_BANKS; k++) begin
      m[k] = (b != BSEL_W'(k));
    end
    return m;
  endfunction

  function automatic logic [31:0] bank_word(input logic [32*NUM_BANKS-1:0] d,
                                            input logic [BSEL_W-1:0]      b);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w = w | ({32{b == BSEL_W'(k)}} & d[32*k +: 32]);
    end
    return w;
  endfunction

  assign hit_s      = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                      (wbs.wbs_adr_i[31:CMP_LO] == BASE_ADDR[31:CMP_LO]);
  assign ctrl_sel_s = wbs.wbs_adr_i[CMP_LO-1];
  assign bus_bank_s = wbs.wbs_adr_i[BANK_AW+BSEL_W+1:BANK_AW+2];
  assign bus_word_s = wbs.wbs_adr_i[BANK_AW+1:2];
  assign bank_ok_s  = ({1'b0, bus_bank_s} < NUM_BANKS_W);
  assign unused_s   = ^wbs.wbs_adr_i[1:0];

`ifdef PROGMEM_CHECKSUM_EN
  logic [31:0] cks_r;
  logic        cks_add_s, cks_clr_s;

  function automatic logic [31:0] byte_masked(input logic [31:0] d, input logic [3:0] m);
    return d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  assign ctrl_reg_s   = ~wbs.wbs_adr_i[2];
  assign ctrl_rdata_s = wbs.wbs_adr_i[2] ? cks_r : {30'h0, wp_r, run_r};
`else
  assign ctrl_reg_s   = 1'b1;
  assign ctrl_rdata_s = {30'h0, wp_r, run_r};
`endif

  // Bus FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bus FSM next-state decode; every transaction runs to ACK even if cyc drops.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          if (!ctrl_sel_s && bank_ok_s) begin
            next_state_s = ST_MEM;
          end else begin
            next_state_s = ST_ACK;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MEM:  next_state_s = ST_WAIT;
      ST_WAIT: next_state_s = ST_ACK;
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered bus, macro port-0 and control outputs.
  always_comb begin
    csb0_s   = '1;
    web0_s   = 1'b1;
    wmask0_s = wmask0_r;
    addr0_s  = addr0_r;
    din0_s   = din0_r;
    dat_o_s  = dat_o_r;
    bank_s   = bank_r;
    we_s     = we_r;
    run_s    = run_r;
    wp_s     = wp_r;
`ifdef PROGMEM_CHECKSUM_EN
    cks_add_s = 1'b0;
    cks_clr_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (hit_s && ctrl_sel_s) begin
          if (wbs.wbs_we_i && ctrl_reg_s && wbs.wbs_sel_i[0]) begin
            run_s = wbs.wbs_dat_i[0];
            wp_s  = wbs.wbs_dat_i[1];
`ifdef PROGMEM_CHECKSUM_EN
            cks_clr_s = wbs.wbs_dat_i[2];
`endif
          end else if (!wbs.wbs_we_i) begin
            dat_o_s = ctrl_rdata_s;
          end else begin
            dat_o_s = dat_o_r;
          end
        end else if (hit_s && !bank_ok_s) begin
          if (!wbs.wbs_we_i) begin
            dat_o_s = 32'h0;
          end else begin
            dat_o_s = dat_o_r;
          end
        end else if (hit_s) begin
          // A protected write still strobes the macro, but as a read whose data is dropped.
          csb0_s   = bank_sel_n(bus_bank_s);
          web0_s   = ~(wbs.wbs_we_i & ~wp_r);
          wmask0_s = wbs.wbs_sel_i;
          addr0_s  = bus_word_s;
          din0_s   = wbs.wbs_dat_i;
          bank_s   = bus_bank_s;
          we_s     = wbs.wbs_we_i;
`ifdef PROGMEM_CHECKSUM_EN
          cks_add_s = wbs.wbs_we_i & ~wp_r;
`endif
        end else begin
          csb0_s = '1;
        end
      end
      ST_WAIT: begin
        if (!we_r) begin
          dat_o_s = bank_word(bank_dout0, bank_r);
        end else begin
          dat_o_s = dat_o_r;
        end
      end
      default: begin
        csb0_s = '1;
      end
    endcase
  end

  // Registered bus, port-0 and control outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r      <= 1'b0;
      dat_o_r    <= 32'h0;
      csb0_r     <= '1;
      web0_r     <= 1'b1;
      wmask0_r   <= 4'h0;
      addr0_r    <= '0;
      din0_r     <= 32'h0;
      bank_r     <= '0;
      we_r       <= 1'b0;
      run_r      <= 1'b0;
      wp_r       <= 1'b0;
      core_rst_r <= 1'b1;
    end else begin
      ack_r      <= (next_state_s == ST_ACK);
      dat_o_r    <= dat_o_s;
      csb0_r     <= csb0_s;
      web0_r     <= web0_s;
      wmask0_r   <= wmask0_s;
      addr0_r    <= addr0_s;
      din0_r     <= din0_s;
      bank_r     <= bank_s;
      we_r       <= we_s;
      run_r      <= run_s;
      wp_r       <= wp_s;
      core_rst_r <= ~run_r;
    end
  end

`ifdef PROGMEM_CHECKSUM_EN
  // Checksum of committed writes; a clear wins over an accumulate.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cks_r <= 32'h0;
    end else if (cks_clr_s) begin
      cks_r <= 32'h0;
    end else if (cks_add_s) begin
      cks_r <= cks_r + byte_masked(wbs.wbs_dat_i, wbs.wbs_sel_i);
    end else begin
      cks_r <= cks_r;
    end
  end
`endif

  // The fetch strobe must reach the macro in the request cycle, so port 1 is driven combinationally.
  assign fetch_bank_s = core_addr[BANK_AW+BSEL_W-1:BANK_AW];
  assign fetch_go_s   = core_req & run_r & ({1'b0, fetch_bank_s} < NUM_BANKS_W);
  assign bank_csb1    = fetch_go_s ? bank_sel_n(fetch_bank_s) : '1;
  assign bank_addr1   = fetch_go_s ? core_addr[BANK_AW-1:0] : '0;

  // Fetch pipeline stage: remembers which bank answers in the next cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fetch_valid_r <= 1'b0;
      fetch_bank_r  <= '0;
    end else begin
      fetch_valid_r <= fetch_go_s;
      fetch_bank_r  <= fetch_go_s ? fetch_bank_s : fetch_bank_r;
    end
  end

  assign core_data = fetch_valid_r ? bank_word(bank_dout1, fetch_bank_r) : 32'h0;
  assign core_valid = fetch_valid_r;
  assign core_rst_o = core_rst_r;

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = dat_o_r;
  assign bank_csb0     = csb0_r;
  assign bank_web0     = web0_r;
  assign bank_wmask0   = wmask0_r;
  assign bank_addr0    = addr0_r;
  assign bank_din0     = din0_r;

endmodule

// File: tb/tb_wb_progmem_banks.sv
// Directed self-checking bench for wb_progmem_banks with a behavioural 1rw1r macro model per bank.
module tb_wb_progmem_banks;
  localparam int          NB   = 2;
  localparam int          AW   = 9;
  localparam logic [31:0] CTRL = 32'h3000_1000;
  localparam logic [31:0] CKS  = 32'h3000_1004;

  logic clk = 1'b0;
  logic rst;
  wb_progmem_banks_if wbs();

  logic [NB-1:0]    bank_csb0, bank_csb1;
  logic             bank_web0;
  logic [3:0]       bank_wmask0;
  logic [AW-1:0]    bank_addr0, bank_addr1;
  logic [31:0]      bank_din0;
  logic [32*NB-1:0] bank_dout0 = '0;
  logic [32*NB-1:0] bank_dout1 = '0;
  logic             core_req;
  logic [AW:0]      core_addr;
  logic [31:0]      core_data;
  logic             core_valid, core_rst_o;

  int n_vec = 0;
  int n_err = 0;

  logic [NB-1:0] obs_csb;
  logic          obs_web, obs_web_low;
  logic [AW-1:0] obs_addr;

  wb_progmem_banks #(.NUM_BANKS(NB), .BANK_AW(AW), .BASE_ADDR(32'h3000_0000), .BSEL_W(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs),
    .bank_csb0(bank_csb0), .bank_web0(bank_web0), .bank_wmask0(bank_wmask0),
    .bank_addr0(bank_addr0), .bank_din0(bank_din0), .bank_dout0(bank_dout0),
    .bank_csb1(bank_csb1), .bank_addr1(bank_addr1), .bank_dout1(bank_dout1),
    .core_req(core_req), .core_addr(core_addr), .core_data(core_data),
    .core_valid(core_valid), .core_rst_o(core_rst_o)
  );

  always #5 clk = ~clk;

  // Macro model: word w of bank b preloads as 0xB00b_0www; dout updates on the clock edge.
  logic [31:0] mem [0:NB*512-1];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NB*512; i++) mem[i] <= 32'hB000_0000 | ((i / 512) << 16) | (i % 512);
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (!bank_csb0[k]) begin
          if (!bank_web0) begin
            for (int j = 0; j < 4; j++)
              if (bank_wmask0[j]) mem[k*512 + int'(bank_addr0)][8*j +: 8] <= bank_din0[8*j +: 8];
          end else begin
            bank_dout0[32*k +: 32] <= mem[k*512 + int'(bank_addr0)];
          end
        end
        if (!bank_csb1[k]) bank_dout1[32*k +: 32] <= mem[k*512 + int'(bank_addr1)];
      end
    end
  end

  function automatic logic [31:0] maddr(input int b, input int w);
    return 32'h3000_0000 | 32'(b << 11) | 32'(w << 2);
  endfunction

  // One Wishbone transfer; lat is the negedge count at which ack was seen, -1 if none in 20 cycles.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    lat = -1;
    rdata = 32'h0;
    obs_web_low = 1'b0;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
    wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = dat;  wbs.wbs_sel_i = sel;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        obs_csb = bank_csb0; obs_web = bank_web0; obs_addr = bank_addr0;
      end
      if (!bank_web0) obs_web_low = 1'b1;
      if (wbs.wbs_ack_o) begin
        lat = c;
        rdata = wbs.wbs_dat_o;
        break;
      end
    end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    core_req = 1'b1; core_addr = 10'h001;
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0;
    wbs.wbs_adr_i = CTRL; wbs.wbs_dat_i = 32'h0; wbs.wbs_sel_i = 4'hF;
    repeat (3) @(negedge clk);
    n_vec++; if (core_rst_o !== 1'b1) begin n_err++; $display("FAIL rst_core_rst: got %b want 1", core_rst_o); end
    n_vec++; if (bank_csb0 !== 2'b11) begin n_err++; $display("FAIL rst_csb0: got %b want 11", bank_csb0); end
    n_vec++; if (bank_csb1 !== 2'b11) begin n_err++; $display("FAIL rst_csb1: got %b want 11", bank_csb1); end
    n_vec++; if (wbs.wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", wbs.wbs_ack_o); end
    n_vec++; if (bank_web0 !== 1'b1) begin n_err++; $display("FAIL rst_web0: got %b want 1", bank_web0); end
    n_vec++; if (core_valid !== 1'b0) begin n_err++; $display("FAIL rst_core_valid: got %b want 0", core_valid); end
    n_vec++; if (wbs.wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat_o: got %h want 0", wbs.wbs_dat_o); end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (bank_csb1 !== 2'b11) begin n_err++; $display("FAIL run0_csb1: got %b want 11", bank_csb1); end
    @(negedge clk);
    n_vec++; if (core_valid !== 1'b0) begin n_err++; $display("FAIL run0_valid: got %b want 0", core_valid); end
    n_vec++; if (core_rst_o !== 1'b1) begin n_err++; $display("FAIL run0_core_rst: got %b want 1", core_rst_o); end
    core_req = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, maddr(1, 5), 32'hDEAD_BEEF, 4'hF, rd, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL wr_lat: got %0d want 3", lat); end
    n_vec++; if (obs_csb !== 2'b01) begin n_err++; $display("FAIL wr_csb0: got %b want 01", obs_csb); end
    n_vec++; if (obs_web !== 1'b0) begin n_err++; $display("FAIL wr_web0: got %b want 0", obs_web); end
    n_vec++; if (obs_addr !== 9'd5) begin n_err++; $display("FAIL wr_addr0: got %0d want 5", obs_addr); end
    wb_xfer(1'b0, maddr(1, 5), 32'h0, 4'hF, rd, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rd_lat: got %0d want 3", lat); end
    n_vec++; if (obs_web !== 1'b1) begin n_err++; $display("FAIL rd_web0: got %b want 1", obs_web); end
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    wb_xfer(1'b1, maddr(1, 5), 32'h1122_3344, 4'b0011, rd, lat);
    wb_xfer(1'b0, maddr(1, 5), 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'hDEAD_3344) begin n_err++; $display("FAIL bytemask_data: got %h want dead3344", rd); end
    wb_xfer(1'b0, 32'h3000_2014, 32'h0, 4'hF, rd, lat);
    n_vec++; if (lat !== -1) begin n_err++; $display("FAIL miss_noack: got %0d want -1", lat); end
  endtask

  task automatic test_write_protect();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, CTRL, 32'h2, 4'hF, rd, lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL ctrl_wr_lat: got %0d want 1", lat); end
    wb_xfer(1'b1, CTRL, 32'h1, 4'b1110, rd, lat);
    wb_xfer(1'b0, CTRL, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL ctrl_sel0_ignored: got %h want 2", rd); end
    wb_xfer(1'b1, maddr(0, 0), 32'h1234_5678, 4'hF, rd, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL wp_lat: got %0d want 3", lat); end
    n_vec++; if (obs_web_low !== 1'b0) begin n_err++; $display("FAIL wp_web0: got low=%b want 0", obs_web_low); end
    n_vec++; if (obs_csb !== 2'b10) begin n_err++; $display("FAIL wp_csb0: got %b want 10", obs_csb); end
    wb_xfer(1'b0, maddr(0, 0), 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'hB000_0000) begin n_err++; $display("FAIL wp_data: got %h want b0000000", rd); end
    wb_xfer(1'b1, CTRL, 32'h0, 4'hF, rd, lat);
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    int lat;
    logic ack_seen;
    ack_seen = 1'b0;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
    wbs.wbs_adr_i = maddr(0, 3); wbs.wbs_dat_i = 32'hCAFE_F00D; wbs.wbs_sel_i = 4'hF;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o) ack_seen = 1'b1;
    end
    n_vec++; if (ack_seen !== 1'b1) begin n_err++; $display("FAIL abort_ack: got %b want 1", ack_seen); end
    wb_xfer(1'b0, maddr(0, 3), 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL abort_data: got %h want cafef00d", rd); end
  endtask

  task automatic test_fetch_stream();
    logic [31:0] rd;
    int lat;
    logic [9:0]  fa [4];
    logic [31:0] fd [4];
    logic [1:0]  fc [4];
    fa = '{10'h000, 10'h001, 10'h200, 10'h201};
    fd = '{32'hB000_0000, 32'hB000_0001, 32'hB001_0000, 32'hB001_0001};
    fc = '{2'b10, 2'b10, 2'b01, 2'b01};
    wb_xfer(1'b1, CTRL, 32'h1, 4'hF, rd, lat);
    repeat (2) @(negedge clk);
    n_vec++; if (core_rst_o !== 1'b0) begin n_err++; $display("FAIL run_core_rst: got %b want 0", core_rst_o); end
    core_req = 1'b1; core_addr = fa[0];
    #1;
    n_vec++; if (bank_csb1 !== fc[0]) begin n_err++; $display("FAIL fetch_csb1_0: got %b want %b", bank_csb1, fc[0]); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_vec++; if (core_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid_%0d: got %b want 1", i-1, core_valid); end
      n_vec++; if (core_data !== fd[i-1]) begin n_err++; $display("FAIL fetch_data_%0d: got %h want %h", i-1, core_data, fd[i-1]); end
      if (i < 4) begin
        core_addr = fa[i];
        #1;
        n_vec++; if (bank_csb1 !== fc[i]) begin n_err++; $display("FAIL fetch_csb1_%0d: got %b want %b", i, bank_csb1, fc[i]); end
      end else begin
        core_req = 1'b0;
      end
    end
    @(negedge clk);
    n_vec++; if (core_valid !== 1'b0) begin n_err++; $display("FAIL fetch_end_valid: got %b want 0", core_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    logic ack_seen;
    ack_seen = 1'b0;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0;
    wbs.wbs_adr_i = maddr(1, 5); wbs.wbs_sel_i = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
    #1;
    if (wbs.wbs_ack_o) ack_seen = 1'b1;
    n_vec++; if (core_rst_o !== 1'b1) begin n_err++; $display("FAIL mid_core_rst: got %b want 1", core_rst_o); end
    n_vec++; if (bank_csb0 !== 2'b11) begin n_err++; $display("FAIL mid_csb0: got %b want 11", bank_csb0); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o) ack_seen = 1'b1;
      if (c == 1) rst = 1'b0;
    end
    n_vec++; if (ack_seen !== 1'b0) begin n_err++; $display("FAIL mid_no_ack: got %b want 0", ack_seen); end
    wb_xfer(1'b0, CTRL, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL mid_ctrl: got %h want 0", rd); end
    core_req = 1'b1; core_addr = 10'h000;
    #1;
    n_vec++; if (bank_csb1 !== 2'b11) begin n_err++; $display("FAIL mid_fetch_csb1: got %b want 11", bank_csb1); end
    @(negedge clk);
    n_vec++; if (core_valid !== 1'b0) begin n_err++; $display("FAIL mid_fetch_valid: got %b want 0", core_valid); end
    core_req = 1'b0;
    wb_xfer(1'b0, maddr(1, 5), 32'h0, 4'hF, rd, lat);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL mid_next_lat: got %0d want 3", lat); end
    n_vec++; if (rd !== 32'hDEAD_3344) begin n_err++; $display("FAIL mid_next_data: got %h want dead3344", rd); end
  endtask

`ifdef PROGMEM_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, CTRL, 32'h4, 4'hF, rd, lat);
    wb_xfer(1'b1, maddr(0, 10), 32'h0000_0001, 4'hF, rd, lat);
    wb_xfer(1'b1, maddr(0, 11), 32'h0000_0002, 4'hF, rd, lat);
    wb_xfer(1'b1, maddr(0, 12), 32'hFFFF_FFFF, 4'hF, rd, lat);
    wb_xfer(1'b0, CKS, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h0000_0002) begin n_err++; $display("FAIL cks_sum: got %h want 00000002", rd); end
    wb_xfer(1'b1, CTRL, 32'h2, 4'hF, rd, lat);
    wb_xfer(1'b1, maddr(0, 13), 32'h0000_0100, 4'hF, rd, lat);
    wb_xfer(1'b1, CTRL, 32'h0, 4'hF, rd, lat);
    wb_xfer(1'b0, CKS, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h0000_0002) begin n_err++; $display("FAIL cks_wp_skip: got %h want 00000002", rd); end
    wb_xfer(1'b1, maddr(0, 14), 32'hFFFF_FFFF, 4'b0001, rd, lat);
    wb_xfer(1'b0, CKS, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h0000_0101) begin n_err++; $display("FAIL cks_masked: got %h want 00000101", rd); end
    wb_xfer(1'b1, CTRL, 32'h4, 4'hF, rd, lat);
    wb_xfer(1'b0, CKS, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL cks_clear: got %h want 0", rd); end
  endtask
`else
  task automatic test_checksum();
    logic [31:0] rd;
    int lat;
    wb_xfer(1'b1, CTRL, 32'h2, 4'hF, rd, lat);
    wb_xfer(1'b0, CKS, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h2) begin n_err++; $display("FAIL alias_rd: got %h want 2", rd); end
    wb_xfer(1'b1, CKS, 32'h1, 4'hF, rd, lat);
    wb_xfer(1'b0, CTRL, 32'h0, 4'hF, rd, lat);
    n_vec++; if (rd !== 32'h1) begin n_err++; $display("FAIL alias_wr: got %h want 1", rd); end
    wb_xfer(1'b1, CTRL, 32'h0, 4'hF, rd, lat);
  endtask
`endif

  initial begin
    rst = 1'b1;
    core_req = 1'b0; core_addr = '0;
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = 4'h0; wbs.wbs_adr_i = 32'h0; wbs.wbs_dat_i = 32'h0;
    test_reset();
    test_write_read();
    test_write_protect();
    test_abort();
    test_fetch_stream();
    test_reset_mid();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
